// File: rtl/jtdsp16_pc_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtdsp16_pc_seq_if                                            |
// | Description : Decoder <-> program sequencer bundle. The decoder side       |
// |               (master) drives clock enable, jump/call/return controls,     |
// |               IRQ request and do-loop set-up. The sequencer side (slave)   |
// |               returns the fetch address and sequencer status.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface jtdsp16_pc_seq_if #(
    parameter int unsigned AW     = 16,
    parameter int unsigned CNTW   = 11,
    parameter int unsigned LDEPTH = 2
) ();
    localparam int unsigned c_lw = $clog2(LDEPTH + 1);

    // decoder controls
    logic            cen;
    logic            goto;
    logic            call;
    logic            ret;
    logic            iret;
    logic [AW-1:0]   target;
    logic            irq_req;
    logic            do_start;
    logic [AW-1:0]   do_len;
    logic [CNTW-1:0] do_cnt;

    // sequencer status
    logic [AW-1:0]   rom_addr;
    logic [AW-1:0]   pr_out;
    logic [AW-1:0]   pi_out;
    logic            in_irq;
    logic            irq_ack;
    logic [c_lw-1:0] loop_lvl;
    logic            ovf_err;

    modport master (
        output cen, goto, call, ret, iret, target, irq_req, do_start, do_len, do_cnt,
        input  rom_addr, pr_out, pi_out, in_irq, irq_ack, loop_lvl, ovf_err
    );

    modport slave (
        input  cen, goto, call, ret, iret, target, irq_req, do_start, do_len, do_cnt,
        output rom_addr, pr_out, pi_out, in_irq, irq_ack, loop_lvl, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/jtdsp16_pc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtdsp16_pc_seq                                               |
// | Description : Program sequencer. Produces one ROM fetch address per cen    |
// |               cycle from jumps, calls, returns, IRQ entry/exit and nested  |
// |               hardware do-loops. All outputs are registered.               |
// |               Build option: define JTDSP16_CALL_STACK_EN to turn the       |
// |               single return register into an RDEPTH-entry return stack.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtdsp16_pc_seq #(
    parameter int unsigned AW     = 16,
    parameter int unsigned LDEPTH = 2,
    parameter int unsigned CNTW   = 11,
    parameter int unsigned IRQVEC = 1,
    parameter int unsigned RDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    jtdsp16_pc_seq_if.slave bus
);
    localparam int unsigned     c_lw      = $clog2(LDEPTH + 1);
    localparam logic [AW-1:0]   c_irq_vec = AW'(IRQVEC);
    localparam logic [c_lw-1:0] c_lfull   = c_lw'(LDEPTH);
    localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);

    // core program state
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_pi;
    logic            r_in_irq;
    logic            r_irq_ack;
    logic            r_ovf;

    // loop stack, entry 0 is the innermost (active) loop
    logic [c_lw-1:0] r_lvl;
    logic [AW-1:0]   r_lp_end  [LDEPTH];
    logic [AW-1:0]   r_lp_head [LDEPTH];
    logic [CNTW-1:0] r_lp_cnt  [LDEPTH];

    // return address storage view
    logic [AW-1:0]   w_pr_top;
    logic            w_rs_full;
    logic            w_rs_empty;

    // per-cycle decisions
    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_pc_nxt;
    logic            w_jump;
    logic            w_lp_match;
    logic            w_take;
    logic            w_lp_push;
    logic            w_lp_pop;
    logic            w_lp_dec;
    logic            w_rs_push;
    logic            w_rs_pop;
    logic            w_leave_irq;
    logic            w_set_err;
    logic [CNTW-1:0] w_new_cnt;

    assign w_pc_inc   = r_pc + 1'b1;
    assign w_jump     = bus.goto | bus.call | bus.ret | bus.iret;
    assign w_lp_match = (r_lvl != '0) && (r_pc == r_lp_end[0]);
    // a zero iteration count still runs the body once
    assign w_new_cnt  = (bus.do_cnt == '0) ? c_cnt_one : bus.do_cnt;

    // Priority chain: IRQ entry, then jumps (goto>call>ret>iret), then loop set-up, then loop end-match
    always_comb begin
        w_pc_nxt    = w_pc_inc;
        w_take      = 1'b0;
        w_lp_push   = 1'b0;
        w_lp_pop    = 1'b0;
        w_lp_dec    = 1'b0;
        w_rs_push   = 1'b0;
        w_rs_pop    = 1'b0;
        w_leave_irq = 1'b0;
        w_set_err   = 1'b0;
        if (bus.irq_req && !r_in_irq && (r_lvl == '0) && !w_jump) begin
            w_take   = 1'b1;
            w_pc_nxt = c_irq_vec;
        end else if (bus.goto) begin
            w_pc_nxt = bus.target;
        end else if (bus.call) begin
            w_pc_nxt  = bus.target;
            w_rs_push = 1'b1;
            w_set_err = w_rs_full;
        end else if (bus.ret) begin
            w_pc_nxt  = w_pr_top;
            w_rs_pop  = 1'b1;
            w_set_err = w_rs_empty;
        end else if (bus.iret) begin
            w_pc_nxt    = r_pi;
            w_leave_irq = 1'b1;
            w_set_err   = !r_in_irq;
        end else if (bus.do_start) begin
            if (bus.do_len != '0) begin
                if (r_lvl == c_lfull) begin
                    w_set_err = 1'b1;
                end else begin
                    w_lp_push = 1'b1;
                end
            end
        end else if (w_lp_match) begin
            if (r_lp_cnt[0] > c_cnt_one) begin
                w_pc_nxt = r_lp_head[0];
                w_lp_dec = 1'b1;
            end else begin
                w_lp_pop = 1'b1;
            end
        end
    end

    // Program counter, IRQ context and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= '0;
            r_pi      <= '0;
            r_in_irq  <= 1'b0;
            r_irq_ack <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (bus.cen) begin
            r_pc      <= w_pc_nxt;
            r_irq_ack <= w_take;
            if (w_take) begin
                r_pi     <= r_pc;
                r_in_irq <= 1'b1;
            end else if (w_leave_irq) begin
                r_in_irq <= 1'b0;
            end
            if (w_set_err) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Loop stack: push shifts entries deeper, pop shifts them back up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl <= '0;
            for (int i = 0; i < int'(LDEPTH); i++) begin
                r_lp_end[i]  <= '0;
                r_lp_head[i] <= '0;
                r_lp_cnt[i]  <= '0;
            end
        end else if (bus.cen) begin
            if (w_lp_push) begin
                for (int i = int'(LDEPTH) - 1; i > 0; i--) begin
                    r_lp_end[i]  <= r_lp_end[i-1];
                    r_lp_head[i] <= r_lp_head[i-1];
                    r_lp_cnt[i]  <= r_lp_cnt[i-1];
                end
                r_lp_end[0]  <= r_pc + bus.do_len;
                r_lp_head[0] <= w_pc_inc;
                r_lp_cnt[0]  <= w_new_cnt;
                r_lvl        <= r_lvl + 1'b1;
            end else if (w_lp_pop) begin
                for (int i = 0; i < int'(LDEPTH) - 1; i++) begin
                    r_lp_end[i]  <= r_lp_end[i+1];
                    r_lp_head[i] <= r_lp_head[i+1];
                    r_lp_cnt[i]  <= r_lp_cnt[i+1];
                end
                r_lp_end[LDEPTH-1]  <= '0;
                r_lp_head[LDEPTH-1] <= '0;
                r_lp_cnt[LDEPTH-1]  <= '0;
                r_lvl               <= r_lvl - 1'b1;
            end else if (w_lp_dec) begin
                r_lp_cnt[0] <= r_lp_cnt[0] - 1'b1;
            end
        end
    end

`ifdef JTDSP16_CALL_STACK_EN
    localparam int unsigned     c_rw    = $clog2(RDEPTH + 1);
    localparam logic [c_rw-1:0] c_rfull = c_rw'(RDEPTH);

    logic [AW-1:0]   r_rs [RDEPTH];
    logic [c_rw-1:0] r_rs_cnt;

    // Unused entries are kept at zero, so popping an empty stack yields 0
    assign w_pr_top   = r_rs[0];
    assign w_rs_full  = (r_rs_cnt == c_rfull);
    assign w_rs_empty = (r_rs_cnt == '0);

    // Return stack: a push when full drops the oldest entry off the bottom
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs_cnt <= '0;
            for (int i = 0; i < int'(RDEPTH); i++) begin
                r_rs[i] <= '0;
            end
        end else if (bus.cen) begin
            if (w_rs_push) begin
                for (int i = int'(RDEPTH) - 1; i > 0; i--) begin
                    r_rs[i] <= r_rs[i-1];
                end
                r_rs[0] <= w_pc_inc;
                if (!w_rs_full) begin
                    r_rs_cnt <= r_rs_cnt + 1'b1;
                end
            end else if (w_rs_pop) begin
                for (int i = 0; i < int'(RDEPTH) - 1; i++) begin
                    r_rs[i] <= r_rs[i+1];
                end
                r_rs[RDEPTH-1] <= '0;
                if (!w_rs_empty) begin
                    r_rs_cnt <= r_rs_cnt - 1'b1;
                end
            end
        end
    end
`else
    logic [AW-1:0] r_pr;
    logic          w_unused_cfg;

    // Single return register: ret reads it without consuming it
    assign w_pr_top     = r_pr;
    assign w_rs_full    = 1'b0;
    assign w_rs_empty   = 1'b0;
    assign w_unused_cfg = ^{RDEPTH, w_rs_pop};

    // Return register: overwritten by every call
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr <= '0;
        end else if (bus.cen && w_rs_push) begin
            r_pr <= w_pc_inc;
        end
    end
`endif

    assign bus.rom_addr = r_pc;
    assign bus.pr_out   = w_pr_top;
    assign bus.pi_out   = r_pi;
    assign bus.in_irq   = r_in_irq;
    assign bus.irq_ack  = r_irq_ack;
    assign bus.loop_lvl = r_lvl;
    assign bus.ovf_err  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_pc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtdsp16_pc_seq                                            |
// | Description : Self-checking bench for jtdsp16_pc_seq: directed scenarios   |
// |               plus randomized control traffic against a queue-based model. |
// |               JTDSP16_CALL_STACK_EN selects the return-stack scenarios.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtdsp16_pc_seq;
    localparam int unsigned AW     = 16;
    localparam int unsigned LDEPTH = 2;
    localparam int unsigned CNTW   = 11;
    localparam int unsigned IRQVEC = 1;
    localparam int unsigned RDEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtdsp16_pc_seq_if #(.AW(AW), .CNTW(CNTW), .LDEPTH(LDEPTH)) bus ();

    jtdsp16_pc_seq #(
        .AW(AW), .LDEPTH(LDEPTH), .CNTW(CNTW), .IRQVEC(IRQVEC), .RDEPTH(RDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    typedef struct {
        logic [15:0] e;
        logic [15:0] h;
        int          cnt;
    } loop_t;

    logic [15:0] m_pc, m_pi;
    bit          m_in_irq, m_ack, m_ovf;
    loop_t       m_loops[$];
`ifdef JTDSP16_CALL_STACK_EN
    logic [15:0] m_rs[$];
`else
    logic [15:0] m_pr;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pr();
`ifdef JTDSP16_CALL_STACK_EN
        return (m_rs.size() == 0) ? 16'd0 : m_rs[m_rs.size()-1];
`else
        return m_pr;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(m_pc));
        chk({tag, ".pr_out"},   32'(bus.pr_out),   32'(exp_pr()));
        chk({tag, ".pi_out"},   32'(bus.pi_out),   32'(m_pi));
        chk({tag, ".in_irq"},   32'(bus.in_irq),   32'(m_in_irq));
        chk({tag, ".irq_ack"},  32'(bus.irq_ack),  32'(m_ack));
        chk({tag, ".loop_lvl"}, 32'(bus.loop_lvl), 32'(m_loops.size()));
        chk({tag, ".ovf_err"},  32'(bus.ovf_err),  32'(m_ovf));
    endtask

    task automatic drive_clear();
        bus.cen      = 1'b1;
        bus.goto     = 1'b0;
        bus.call     = 1'b0;
        bus.ret      = 1'b0;
        bus.iret     = 1'b0;
        bus.target   = '0;
        bus.irq_req  = 1'b0;
        bus.do_start = 1'b0;
        bus.do_len   = '0;
        bus.do_cnt   = '0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_pi = 0; m_in_irq = 0; m_ack = 0; m_ovf = 0;
        m_loops.delete();
`ifdef JTDSP16_CALL_STACK_EN
        m_rs.delete();
`else
        m_pr = 0;
`endif
    endtask

    // One cen cycle of the sequencer, written from the behavioural rules
    task automatic model_step();
        logic [15:0] nxt;
        bit          jump, take;
        int          top;
        if (!bus.cen) return;
        jump = bus.goto || bus.call || bus.ret || bus.iret;
        take = bus.irq_req && !m_in_irq && (m_loops.size() == 0) && !jump;
        nxt  = m_pc + 16'd1;
        m_ack = take;
        top  = m_loops.size() - 1;
        if (take) begin
            m_pi = m_pc; m_in_irq = 1; nxt = 16'(IRQVEC);
        end else if (bus.goto) begin
            nxt = bus.target;
        end else if (bus.call) begin
            nxt = bus.target;
`ifdef JTDSP16_CALL_STACK_EN
            if (m_rs.size() == RDEPTH) begin
                m_ovf = 1;
                void'(m_rs.pop_front());
            end
            m_rs.push_back(m_pc + 16'd1);
`else
            m_pr = m_pc + 16'd1;
`endif
        end else if (bus.ret) begin
`ifdef JTDSP16_CALL_STACK_EN
            if (m_rs.size() == 0) begin
                m_ovf = 1; nxt = 0;
            end else begin
                nxt = m_rs.pop_back();
            end
`else
            nxt = m_pr;
`endif
        end else if (bus.iret) begin
            nxt = m_pi;
            if (!m_in_irq) m_ovf = 1;
            m_in_irq = 0;
        end else if (bus.do_start) begin
            if (bus.do_len != 0) begin
                if (m_loops.size() == LDEPTH) m_ovf = 1;
                else m_loops.push_back('{e: m_pc + bus.do_len, h: m_pc + 16'd1,
                                         cnt: (bus.do_cnt == 0) ? 1 : int'(bus.do_cnt)});
            end
        end else if (top >= 0 && m_pc == m_loops[top].e) begin
            if (m_loops[top].cnt > 1) begin
                nxt = m_loops[top].h;
                m_loops[top].cnt = m_loops[top].cnt - 1;
            end else begin
                void'(m_loops.pop_back());
            end
        end
        m_pc = nxt;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        drive_clear();
    endtask

    task automatic do_reset(input bit c);
        drive_clear();
        bus.cen = c;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
        bus.cen = 1'b1;
    endtask

    logic [15:0] t2 [7]  = '{16'd11, 16'd12, 16'd11, 16'd12, 16'd11, 16'd12, 16'd13};
    logic [15:0] t3 [13] = '{16'd21, 16'd22, 16'd23, 16'd22, 16'd23, 16'd24, 16'd21,
                             16'd22, 16'd23, 16'd22, 16'd23, 16'd24, 16'd25};

    initial begin
        drive_clear();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // reset with cen low still clears everything
        do_reset(1'b0);
        chk("t1_reset_addr", 32'(bus.rom_addr), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick("t1_run");
            chk("t1_seq", 32'(bus.rom_addr), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            bus.cen = 1'b0;
            tick("t1_hold");
            chk("t1_frozen", 32'(bus.rom_addr), 32'd4);
        end

        // single loop: body 11..12 three times
        bus.goto = 1'b1; bus.target = 16'd10; tick("t2_goto");
        bus.do_start = 1'b1; bus.do_len = 16'd2; bus.do_cnt = 11'd3; tick("t2_do");
        for (int i = 0; i < 7; i++) begin
            chk("t2_addr", 32'(bus.rom_addr), 32'(t2[i]));
            chk("t2_lvl", 32'(bus.loop_lvl), (i < 6) ? 32'd1 : 32'd0);
            if (i < 6) tick("t2_run");
        end

        // nested loops: do at 20 (len 4 cnt 2), do at 21 (len 2 cnt 2)
        bus.goto = 1'b1; bus.target = 16'd20; tick("t3_goto");
        bus.do_start = 1'b1; bus.do_len = 16'd4; bus.do_cnt = 11'd2; tick("t3_outer");
        for (int i = 0; i < 13; i++) begin
            chk("t3_addr", 32'(bus.rom_addr), 32'(t3[i]));
            if (i < 12) begin
                if (t3[i] == 16'd21) begin
                    bus.do_start = 1'b1; bus.do_len = 16'd2; bus.do_cnt = 11'd2;
                end
                tick("t3_run");
            end
        end

        // IRQ entry/exit and deferral inside a loop
        do_reset(1'b1);
        bus.goto = 1'b1; bus.target = 16'd40; tick("t4_goto");
        bus.irq_req = 1'b1; tick("t4_take");
        chk("t4_vec", 32'(bus.rom_addr), 32'd1);
        chk("t4_ack", 32'(bus.irq_ack), 32'd1);
        chk("t4_pi", 32'(bus.pi_out), 32'd40);
        tick("t4_after");
        chk("t4_ack_pulse", 32'(bus.irq_ack), 32'd0);
        bus.iret = 1'b1; tick("t4_iret");
        chk("t4_iret_addr", 32'(bus.rom_addr), 32'd40);
        chk("t4_iret_inirq", 32'(bus.in_irq), 32'd0);
        bus.goto = 1'b1; bus.target = 16'd50; tick("t4_goto2");
        bus.do_start = 1'b1; bus.do_len = 16'd3; bus.do_cnt = 11'd1; tick("t4_do");
        for (int i = 0; i < 3; i++) begin
            bus.irq_req = 1'b1; tick("t4_defer");
            chk("t4_defer_ack", 32'(bus.irq_ack), 32'd0);
        end
        chk("t4_loop_exit", 32'(bus.rom_addr), 32'd54);
        bus.irq_req = 1'b1; tick("t4_take2");
        chk("t4_vec2", 32'(bus.rom_addr), 32'd1);
        chk("t4_pi2", 32'(bus.pi_out), 32'd54);
        bus.irq_req = 1'b1; tick("t4_nested_irq");
        chk("t4_no_reentry", 32'(bus.irq_ack), 32'd0);

        // return address handling
        do_reset(1'b1);
`ifdef JTDSP16_CALL_STACK_EN
        bus.goto = 1'b1; bus.target = 16'd10; tick("t5_goto");
        for (int i = 2; i <= 5; i++) begin
            bus.call = 1'b1; bus.target = 16'(10 * i); tick("t5_call");
        end
        chk("t5_top", 32'(bus.pr_out), 32'd41);
        for (int i = 4; i >= 1; i--) begin
            bus.ret = 1'b1; tick("t5_ret");
            chk("t5_lifo", 32'(bus.rom_addr), 32'(10 * i + 1));
        end
        chk("t5_no_err", 32'(bus.ovf_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.call = 1'b1; bus.target = 16'(100 + i); tick("t5_fill");
        end
        chk("t5_overflow", 32'(bus.ovf_err), 32'd1);
`else
        bus.goto = 1'b1; bus.target = 16'd7; tick("t6_goto");
        bus.call = 1'b1; bus.target = 16'd100; tick("t6_call1");
        chk("t6_pr1", 32'(bus.pr_out), 32'd8);
        bus.call = 1'b1; bus.target = 16'd200; tick("t6_call2");
        bus.ret = 1'b1; tick("t6_ret");
        chk("t6_ret_addr", 32'(bus.rom_addr), 32'd101);
        chk("t6_pr_kept", 32'(bus.pr_out), 32'd101);
`endif

        // loop stack overflow
        do_reset(1'b1);
        bus.goto = 1'b1; bus.target = 16'd300; tick("t6_goto");
        bus.do_start = 1'b1; bus.do_len = 16'd10; bus.do_cnt = 11'd1; tick("t6_do1");
        bus.do_start = 1'b1; bus.do_len = 16'd5;  bus.do_cnt = 11'd1; tick("t6_do2");
        chk("t6_no_err", 32'(bus.ovf_err), 32'd0);
        bus.do_start = 1'b1; bus.do_len = 16'd3;  bus.do_cnt = 11'd1; tick("t6_do3");
        chk("t6_loop_ovf", 32'(bus.ovf_err), 32'd1);
        chk("t6_lvl", 32'(bus.loop_lvl), 32'd2);
        chk("t6_addr", 32'(bus.rom_addr), 32'd303);

        // zero-length loop ignored, zero count runs once, stray iret
        do_reset(1'b1);
        bus.goto = 1'b1; bus.target = 16'd60; tick("t7_goto");
        bus.do_start = 1'b1; bus.do_len = 16'd0; bus.do_cnt = 11'd5; tick("t7_len0");
        chk("t7_len0_lvl", 32'(bus.loop_lvl), 32'd0);
        bus.do_start = 1'b1; bus.do_len = 16'd1; bus.do_cnt = 11'd0; tick("t7_cnt0");
        tick("t7_body");
        chk("t7_cnt0_exit", 32'(bus.rom_addr), 32'd63);
        bus.iret = 1'b1; tick("t7_iret");
        chk("t7_iret_addr", 32'(bus.rom_addr), 32'd0);
        chk("t7_iret_err", 32'(bus.ovf_err), 32'd1);

        // randomized traffic against the model
        do_reset(1'b1);
        for (int i = 0; i < 600; i++) begin
            int sel;
            if (i % 150 == 149) do_reset(1'b1);
            bus.cen     = ($urandom % 8) != 0;
            bus.irq_req = ($urandom % 6) == 0;
            bus.target  = 16'($urandom % 64);
            bus.do_len  = 16'($urandom % 5);
            bus.do_cnt  = 11'($urandom % 4);
            sel = int'($urandom % 16);
            case (sel)
                0:       bus.goto = 1'b1;
                1:       bus.call = 1'b1;
                2:       bus.ret  = 1'b1;
                3:       bus.iret = 1'b1;
                4, 5, 6: bus.do_start = 1'b1;
                15: begin
                    bus.goto     = 1'($urandom % 2);
                    bus.call     = 1'($urandom % 2);
                    bus.ret      = 1'($urandom % 2);
                    bus.iret     = 1'($urandom % 2);
                    bus.do_start = 1'($urandom % 2);
                end
                default: ;
            endcase
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
